// File: rtl/pipeline_hazard_ctrl.sv
// ID-stage hazard detection, forwarding selects and multiply/divide busy sequencing
// for the five-stage pipeline, plus a free-running stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic [1:0]  ID_tuseRs,
  input  logic [1:0]  ID_tuseRt,
  input  logic        ID_isMD,
  input  logic [4:0]  EX_wreg,
  input  logic [4:0]  MEM_wreg,
  input  logic        EX_RegWrite,
  input  logic        MEM_RegWrite,
  input  logic [1:0]  EX_timeNew,
  input  logic [1:0]  MEM_timeNew,
  input  logic        EX_mdStart,
  input  logic        EX_mdOp,
  output logic        stall,
  output logic [1:0]  ID_fwdRs,
  output logic [1:0]  ID_fwdRt,
  output logic        mdBusy,
  output logic        mdOverrun,
  output logic [31:0] stallCount
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_e;

  md_state_e   state_q;
  logic [3:0]  cnt_q;
  logic        overrun_q;
  logic [31:0] stall_cnt_q;

  logic [4:0] src      [2];
  logic [1:0] tuse     [2];
  logic [1:0] fwd      [2];
  logic [1:0] hz_ex;
  logic [1:0] hz_mem;
  logic       hz_md;

  assign src[0]  = ID_rs;
  assign src[1]  = ID_rt;
  assign tuse[0] = ID_tuseRs;
  assign tuse[1] = ID_tuseRt;

  // Tuse of 3 marks an unused operand; timeNew never exceeds 2, so it never hazards.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      logic match_ex;
      logic match_mem;
      assign match_ex  = (src[gi] != 5'd0) && EX_RegWrite  && (EX_wreg  == src[gi]);
      assign match_mem = (src[gi] != 5'd0) && MEM_RegWrite && (MEM_wreg == src[gi]);
      assign hz_ex[gi]  = match_ex  && (EX_timeNew  > tuse[gi]);
      assign hz_mem[gi] = match_mem && (MEM_timeNew > tuse[gi]);
      assign fwd[gi] = (match_ex  && (EX_timeNew  == 2'd0)) ? 2'd1 :
                       (match_mem && (MEM_timeNew == 2'd0)) ? 2'd2 : 2'd0;
    end
  endgenerate

  assign mdBusy     = (state_q == BUSY);
  assign hz_md      = ID_isMD && (mdBusy || EX_mdStart);
  assign stall      = (|hz_ex) || (|hz_mem) || hz_md;
  assign ID_fwdRs   = fwd[0];
  assign ID_fwdRt   = fwd[1];
  assign mdOverrun  = overrun_q;
  assign stallCount = stall_cnt_q;

  // A start arriving while busy is dropped and only flagged; the running count is untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      overrun_q   <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      case (state_q)
        IDLE: begin
          if (EX_mdStart) begin
            cnt_q   <= EX_mdOp ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (EX_mdStart) overrun_q <= 1'b1;
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
